synth_cmd_sequencer: RTL and testbench

// - Synthesizable, parametrised note-command player; replaces hand-timed write stimulus with an on-chip script.
// - Stores DEPTH entries {delay, cmd}. Each cmd uses the synthesizer format: [15]=on/off, [14:8]=note, [7:0]=velocity.
// - Issues each cmd as an Avalon-MM write into synthesizer_top_p avs_s0 after its programmed delay.
// - Used for on-board self-test and repeatable regression stimulus.

---
 rtl/synth_cmd_sequencer_if.sv | 11 +
 rtl/synth_cmd_sequencer.sv | 142 ++++++++++++++
 tb/tb_synth_cmd_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_cmd_sequencer_if.sv
// Avalon-MM write-only master channel driven by synth_cmd_sequencer into the synthesizer avs_s0 port.
interface synth_cmd_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;

  modport master (output avm_write, avm_writedata, input avm_waitrequest);
  modport slave  (input avm_write, avm_writedata, output avm_waitrequest);
endinterface

// File: rtl/synth_cmd_sequencer.sv
// Scripted note-command player: replays DEPTH {delay, cmd} entries as Avalon-MM writes.
// Optional feature macro SYNTH_SEQ_LOOP_EN enables looping playback through i_loop.
module synth_cmd_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int DELAY_W = 24,
  parameter int CMD_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load_en,
  input  logic [ADDR_W-1:0]   i_load_addr,
  input  logic [DELAY_W-1:0]  i_load_delay,
  input  logic [CMD_W-1:0]    i_load_cmd,
  input  logic [ADDR_W:0]     i_len,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_loop,
  synth_cmd_sequencer_if.master avm,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_index
);

  localparam logic [CMD_W-1:0] STOP_ALL = CMD_W'(16'h7F00);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_ISSUE, S_DONE, S_ABORT
  } state_t;

  logic [DELAY_W+CMD_W-1:0] r_ram [DEPTH];
  logic [DELAY_W-1:0]       r_rd_delay;
  logic [CMD_W-1:0]         r_rd_cmd;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDR_W-1:0]        r_index;
  logic [ADDR_W:0]          r_len;
  logic [DELAY_W-1:0]       r_cnt;
  logic [DATA_W-1:0]        r_wdata;
  logic                     r_abort_pend;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_loop;
  logic [ADDR_W:0]          w_len_clamped;

`ifdef SYNTH_SEQ_LOOP_EN
  assign w_loop = i_loop;
`else
  // One-shot build: the port stays for pin compatibility but never takes effect.
  assign w_loop = i_loop & 1'b0;
`endif

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_index       = r_index;
  assign avm.avm_write = (r_state == S_ISSUE) || (r_state == S_ABORT);
  assign avm.avm_writedata = r_wdata;

  assign w_accept      = avm.avm_write && !avm.avm_waitrequest;
  assign w_last        = ({1'b0, r_index} + (ADDR_W+1)'(1)) == r_len;
  assign w_len_clamped = (i_len > DEPTH_L) ? DEPTH_L : i_len;

  // NOTE: the script RAM has no reset so it maps onto block RAM and survives a reset.
  always_ff @(posedge clk) begin
    if (i_load_en && !o_busy) begin
      r_ram[i_load_addr] <= {i_load_delay, i_load_cmd};
    end
    {r_rd_delay, r_rd_cmd} <= r_ram[r_index];
  end

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = (w_len_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next_state = i_abort ? S_ABORT : S_LOAD;
      S_LOAD: begin
        if (i_abort)                 w_next_state = S_ABORT;
        else if (r_rd_delay == '0)   w_next_state = S_ISSUE;
        else                         w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (i_abort)                         w_next_state = S_ABORT;
        else if (r_cnt == DELAY_W'(1))       w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_accept) begin
          if (i_abort || r_abort_pend) w_next_state = S_ABORT;
          else if (w_last && !w_loop)  w_next_state = S_DONE;
          else                         w_next_state = S_FETCH;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ABORT: if (w_accept) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_index      <= '0;
            r_len        <= w_len_clamped;
            r_abort_pend <= 1'b0;
          end
        end
        S_LOAD:  r_cnt <= r_rd_delay;
        S_WAIT:  r_cnt <= r_cnt - DELAY_W'(1);
        S_ISSUE: begin
          if (i_abort) r_abort_pend <= 1'b1;
          if (w_accept && w_next_state == S_FETCH) begin
            r_index <= w_last ? '0 : r_index + ADDR_W'(1);
          end
        end
        S_ABORT: if (w_accept) r_index <= '0;
        default: ;
      endcase
      // Write data is captured once on entry so it holds steady through any stall.
      if (w_next_state == S_ISSUE && r_state != S_ISSUE) begin
        r_wdata <= DATA_W'(r_rd_cmd);
      end else if (w_next_state == S_ABORT && r_state != S_ABORT) begin
        r_wdata <= DATA_W'(STOP_ALL);
      end
    end
  end

endmodule

// File: tb/tb_synth_cmd_sequencer.sv
// Directed bench for synth_cmd_sequencer: timing, stalls, abort, length edge cases, looping and reset.
module tb_synth_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_load_en;
  logic [3:0]  i_load_addr;
  logic [23:0] i_load_delay;
  logic [15:0] i_load_cmd;
  logic [4:0]  i_len;
  logic        i_start;
  logic        i_abort;
  logic        i_loop;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_index;

  synth_cmd_sequencer_if #(.DATA_W(32)) avm_if ();

  synth_cmd_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_load_en    (i_load_en),
    .i_load_addr  (i_load_addr),
    .i_load_delay (i_load_delay),
    .i_load_cmd   (i_load_cmd),
    .i_len        (i_len),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_loop       (i_loop),
    .avm          (avm_if.master),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_index      (o_index)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          start_edge;
  int          wr_hi;
  int          wr_in_done;
  int          acc_edge[$];
  logic [31:0] acc_data[$];
  int          done_edge[$];

  // Edge-numbered log of accepted writes and done pulses, sampled with pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (avm_if.avm_write) wr_hi <= wr_hi + 1;
      if (avm_if.avm_write && !avm_if.avm_waitrequest) begin
        acc_edge.push_back(cyc);
        acc_data.push_back(avm_if.avm_writedata);
      end
      if (o_done) begin
        done_edge.push_back(cyc);
        if (avm_if.avm_write) wr_in_done <= wr_in_done + 1;
      end
      if (i_start && !o_busy) start_edge <= cyc;
    end
  end

  task automatic clear_logs();
    acc_edge.delete();
    acc_data.delete();
    done_edge.delete();
    wr_hi      = 0;
    wr_in_done = 0;
  endtask

  task automatic load_entry(input int addr, input int delay, input logic [15:0] cmd);
    i_load_en    = 1'b1;
    i_load_addr  = 4'(addr);
    i_load_delay = 24'(delay);
    i_load_cmd   = cmd;
    @(posedge clk); #1;
    i_load_en    = 1'b0;
  endtask

  task automatic start_play(input int len);
    i_len   = 5'(len);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (!o_busy) break;
    end
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b, required 0", name, o_busy);
    else n_pass++;
  endtask

  task automatic wait_writes(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (acc_data.size() >= n) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({avm_if.avm_write, avm_if.avm_writedata, o_busy, o_done, o_index} !== '0)
      $display("FAIL reset_outputs: write=%b data=%h busy=%b done=%b index=%0d, required all zero",
               avm_if.avm_write, avm_if.avm_writedata, o_busy, o_done, o_index);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_entry(0, 5, 16'hC500);
    load_entry(1, 0, 16'h4500);
    clear_logs();
    start_play(2);
    wait_idle(100, "basic");
    n_checks++;
    if (acc_data.size() !== 2) $display("FAIL basic_count: got %0d writes, required 2", acc_data.size());
    else n_pass++;
    if (acc_data.size() == 2) begin
      n_checks++;
      if (acc_data[0] !== 32'h0000C500 || acc_edge[0] !== start_edge + 8)
        $display("FAIL basic_first: data=%h edge=%0d, required 0000c500 at %0d",
                 acc_data[0], acc_edge[0], start_edge + 8);
      else n_pass++;
      n_checks++;
      if (acc_data[1] !== 32'h00004500 || acc_edge[1] !== acc_edge[0] + 3)
        $display("FAIL basic_second: data=%h edge=%0d, required 00004500 at %0d",
                 acc_data[1], acc_edge[1], acc_edge[0] + 3);
      else n_pass++;
      n_checks++;
      if (done_edge.size() !== 1 || done_edge[0] !== acc_edge[1] + 1)
        $display("FAIL basic_done: pulses=%0d, required one pulse at edge %0d", done_edge.size(), acc_edge[1] + 1);
      else n_pass++;
    end
    n_checks++;
    if (wr_in_done !== 0) $display("FAIL basic_write_in_done: got %0d, required 0", wr_in_done);
    else n_pass++;
  endtask

  task automatic test_stall();
    load_entry(0, 2, 16'h9234);
    clear_logs();
    avm_if.avm_waitrequest = 1'b1;
    start_play(1);
    for (int i = 0; i < 20; i++) begin
      if (avm_if.avm_write) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (avm_if.avm_write !== 1'b1 || avm_if.avm_writedata !== 32'h00009234)
        $display("FAIL stall_hold_%0d: write=%b data=%h, required 1 / 00009234",
                 i, avm_if.avm_write, avm_if.avm_writedata);
      else n_pass++;
      if (i == 3) avm_if.avm_waitrequest = 1'b0;
      @(posedge clk); #1;
    end
    wait_idle(20, "stall");
    n_checks++;
    if (acc_data.size() !== 1 || wr_hi !== 4 || done_edge.size() !== 1)
      $display("FAIL stall_transfers: accepted=%0d high_cycles=%0d done=%0d, required 1/4/1",
               acc_data.size(), wr_hi, done_edge.size());
    else n_pass++;
  endtask

  task automatic test_abort_wait();
    load_entry(0, 1, 16'hC100);
    load_entry(1, 1000, 16'hC200);
    load_entry(2, 0, 16'hC300);
    clear_logs();
    start_play(3);
    wait_writes(1, 50);
    repeat (10) @(posedge clk);
    #1;
    i_abort = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    i_start = 1'b0;
    wait_idle(50, "abort_wait");
    n_checks++;
    if (acc_data.size() !== 2 || acc_data[0] !== 32'h0000C100 || acc_data[1] !== 32'h00007F00)
      $display("FAIL abort_wait_writes: count=%0d last=%h, required 2 writes c100 then 7f00",
               acc_data.size(), acc_data.size() > 0 ? acc_data[acc_data.size()-1] : 32'h0);
    else n_pass++;
    n_checks++;
    if (done_edge.size() !== 0 || o_index !== 4'd0)
      $display("FAIL abort_wait_state: done=%0d index=%0d, required 0/0", done_edge.size(), o_index);
    else n_pass++;
  endtask

  task automatic test_abort_issue();
    load_entry(0, 0, 16'hC400);
    clear_logs();
    avm_if.avm_waitrequest = 1'b1;
    start_play(1);
    for (int i = 0; i < 20; i++) begin
      if (avm_if.avm_write) break;
      @(posedge clk); #1;
    end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    avm_if.avm_waitrequest = 1'b0;
    wait_idle(20, "abort_issue");
    n_checks++;
    if (acc_data.size() !== 2 || acc_data[0] !== 32'h0000C400 || acc_data[1] !== 32'h00007F00 || done_edge.size() !== 0)
      $display("FAIL abort_issue: count=%0d done=%0d, required c400 then 7f00 and no done",
               acc_data.size(), done_edge.size());
    else n_pass++;
  endtask

  task automatic test_len_edges();
    int bad;
    clear_logs();
    start_play(0);
    wait_idle(10, "len0");
    n_checks++;
    if (acc_data.size() !== 0 || done_edge.size() !== 1 || done_edge[0] !== start_edge + 1)
      $display("FAIL len0: writes=%0d done=%0d, required 0 writes and done at edge %0d",
               acc_data.size(), done_edge.size(), start_edge + 1);
    else n_pass++;
    for (int i = 0; i < 16; i++) load_entry(i, 0, 16'h0100 + 16'(i));
    clear_logs();
    start_play(20);
    wait_idle(200, "len20");
    bad = (acc_data.size() == 16) ? 0 : 1;
    for (int i = 0; i < acc_data.size() && i < 16; i++)
      if (acc_data[i] !== 32'h00000100 + 32'(i)) bad++;
    n_checks++;
    if (bad !== 0 || done_edge.size() !== 1)
      $display("FAIL len20_clamp: writes=%0d errors=%0d done=%0d, required 16/0/1",
               acc_data.size(), bad, done_edge.size());
    else n_pass++;
  endtask

  task automatic test_loop();
    int bad;
    clear_logs();
    i_loop = 1'b1;
    start_play(3);
`ifdef SYNTH_SEQ_LOOP_EN
    wait_writes(5, 100);
    i_loop = 1'b0;
    wait_idle(100, "loop");
    bad = (acc_data.size() == 6) ? 0 : 1;
    for (int i = 0; i < acc_data.size() && i < 6; i++)
      if (acc_data[i] !== 32'h00000100 + 32'(i % 3)) bad++;
    n_checks++;
    if (bad !== 0 || done_edge.size() !== 1)
      $display("FAIL loop_sequence: writes=%0d errors=%0d done=%0d, required 6/0/1",
               acc_data.size(), bad, done_edge.size());
    else n_pass++;
`else
    wait_idle(100, "oneshot");
    i_loop = 1'b0;
    bad = (acc_data.size() == 3) ? 0 : 1;
    for (int i = 0; i < acc_data.size() && i < 3; i++)
      if (acc_data[i] !== 32'h00000100 + 32'(i)) bad++;
    n_checks++;
    if (bad !== 0 || done_edge.size() !== 1)
      $display("FAIL oneshot_sequence: writes=%0d errors=%0d done=%0d, required 3/0/1",
               acc_data.size(), bad, done_edge.size());
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_issue();
    int bad;
    clear_logs();
    avm_if.avm_waitrequest = 1'b1;
    start_play(1);
    for (int i = 0; i < 20; i++) begin
      if (avm_if.avm_write) break;
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({avm_if.avm_write, avm_if.avm_writedata, o_busy, o_done, o_index} !== '0)
      $display("FAIL reset_mid_issue: write=%b data=%h busy=%b, required all zero",
               avm_if.avm_write, avm_if.avm_writedata, o_busy);
    else n_pass++;
    #2;
    reset = 1'b0;
    avm_if.avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    start_play(3);
    wait_idle(50, "replay");
    bad = (acc_data.size() == 3) ? 0 : 1;
    for (int i = 0; i < acc_data.size() && i < 3; i++)
      if (acc_data[i] !== 32'h00000100 + 32'(i)) bad++;
    n_checks++;
    if (bad !== 0 || done_edge.size() !== 1)
      $display("FAIL replay_after_reset: writes=%0d errors=%0d done=%0d, required 3/0/1",
               acc_data.size(), bad, done_edge.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    i_load_en = 1'b0; i_load_addr = '0; i_load_delay = '0; i_load_cmd = '0;
    i_len = '0; i_start = 1'b0; i_abort = 1'b0; i_loop = 1'b0;
    avm_if.avm_waitrequest = 1'b0;
    wr_hi = 0; wr_in_done = 0; start_edge = 0;
    test_reset();
    test_basic();
    test_stall();
    test_abort_wait();
    test_abort_issue();
    test_len_edges();
    test_loop();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
